// File: rtl/uart_pkg.sv
// Shared UART definitions: transmitter state encoding and line/parity levels.
// The receive-side checker uses the same constants so both ends agree.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } tx_state_t;

  localparam logic UART_IDLE_LVL  = 1'b1;
  localparam logic UART_START_LVL = 1'b0;
  localparam logic UART_STOP_LVL  = 1'b1;
  localparam logic PAR_EVEN       = 1'b0;
  localparam logic PAR_ODD        = 1'b1;

endpackage

// File: rtl/uart_tx_serializer.sv
// Load/shift register for the UART payload, LSB first, with a bit counter
// and a registered flag that marks when the final payload bit has been handed out.
module uart_tx_serializer #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  load,
  input  logic                  shift,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic                  ser_bit,
  output logic                  last_bit
);

  localparam int CW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DATA_WIDTH - 1);

  logic [DATA_WIDTH-1:0] shreg_q;
  logic [CW-1:0]         cnt_q;
  logic                  last_q;

  // cnt_q holds the index of the bit currently offered on ser_bit; it stops
  // at the last index instead of wrapping, and last_q records that it went out.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shreg_q <= '0;
      cnt_q   <= '0;
      last_q  <= 1'b0;
    end else if (load) begin
      shreg_q <= data_in;
      cnt_q   <= '0;
      last_q  <= 1'b0;
    end else if (shift) begin
      shreg_q <= shreg_q >> 1;
      last_q  <= (cnt_q == CNT_LAST);
      if (cnt_q != CNT_LAST) begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

  assign ser_bit  = shreg_q[0];
  assign last_bit = last_q;

endmodule

// File: rtl/uart_tx_frame_gen.sv
// UART transmitter: accepts a word on Data_Valid && !busy and sends
// start, DATA_WIDTH data bits LSB first, optional parity, stop at one bit per CLK.
//
// state  | meaning
// IDLE   | line high, busy low, waiting for Data_Valid
// START  | start bit (low) on the line
// DATA   | payload bit on the line, one per cycle, LSB first
// PARITY | latched parity bit on the line
// STOP   | stop bit (high); busy still high
module uart_tx_frame_gen
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [DATA_WIDTH-1:0] P_DATA,
  input  logic                  Data_Valid,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  output logic                  TX_OUT,
  output logic                  busy
);

  tx_state_t state_q;
  logic      tx_q;
  logic      busy_q;
  logic      par_en_q;
  logic      par_bit_q;

  logic      accept;
  logic      load;
  logic      shift;
  logic      ser_bit;
  logic      last_bit;

  assign accept = (state_q == IDLE) && Data_Valid && !busy_q;
  assign load   = accept;
  // Shift whenever a payload bit is being moved onto the line register.
  assign shift  = (state_q == START) || ((state_q == DATA) && !last_bit);

  uart_tx_serializer #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_ser (
    .clk     (CLK),
    .rst_n   (RST),
    .load    (load),
    .shift   (shift),
    .data_in (P_DATA),
    .ser_bit (ser_bit),
    .last_bit(last_bit)
  );

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q   <= IDLE;
      tx_q      <= UART_IDLE_LVL;
      busy_q    <= 1'b0;
      par_en_q  <= 1'b0;
      par_bit_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            state_q   <= START;
            tx_q      <= UART_START_LVL;
            busy_q    <= 1'b1;
            par_en_q  <= PAR_EN;
            par_bit_q <= (^P_DATA) ^ PAR_TYP;
          end else begin
            tx_q   <= UART_IDLE_LVL;
            busy_q <= 1'b0;
          end
        end
        START: begin
          state_q <= DATA;
          tx_q    <= ser_bit;
        end
        DATA: begin
          if (last_bit) begin
            if (par_en_q) begin
              state_q <= PARITY;
              tx_q    <= par_bit_q;
            end else begin
              state_q <= STOP;
              tx_q    <= UART_STOP_LVL;
            end
          end else begin
            tx_q <= ser_bit;
          end
        end
        PARITY: begin
          state_q <= STOP;
          tx_q    <= UART_STOP_LVL;
        end
        STOP: begin
          state_q <= IDLE;
          tx_q    <= UART_IDLE_LVL;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= IDLE;
          tx_q    <= UART_IDLE_LVL;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign TX_OUT = tx_q;
  assign busy   = busy_q;

endmodule
